// File: rtl/cpu_sequencer_pkg.sv
// Shared ISA constants for the 8-bit CPU: control state codes, opcodes, helpers.
package cpu_sequencer_pkg;

    localparam int unsigned DEF_OPCODE_W  = 8;
    localparam int unsigned DEF_STATE_W   = 4;
    localparam int unsigned DEF_MAX_STEPS = 8;

    typedef enum logic [3:0] {
        STATE_FETCH_PC   = 4'd0,
        STATE_FETCH_INST = 4'd1,
        STATE_LOAD_ADDR  = 4'd2,
        STATE_RAM_A      = 4'd3,
        STATE_RAM_B      = 4'd4,
        STATE_STORE_A    = 4'd5,
        STATE_ALU_OP     = 4'd6,
        STATE_OUT_A      = 4'd7,
        STATE_JUMP       = 4'd8,
        STATE_HALT       = 4'd9,
        STATE_NEXT       = 4'd10
    } state_e;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_STA = 8'h04;
    localparam logic [7:0] OP_OUT = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h06;
    localparam logic [7:0] OP_JEZ = 8'h07;
    localparam logic [7:0] OP_JNZ = 8'h08;
    localparam logic [7:0] OP_HLT = 8'h0F;

    // States that wait on the memory handshake.
    function automatic logic is_mem_state(input state_e s);
        return (s == STATE_FETCH_INST) || (s == STATE_RAM_A) ||
               (s == STATE_RAM_B)      || (s == STATE_STORE_A);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: opcode/handshake in, control state and flags out.
interface cpu_sequencer_if #(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned STATE_W  = 4,
    parameter int unsigned STEP_W   = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_stall;
    logic                resume;
    logic [STATE_W-1:0]  state;
    logic [STEP_W-1:0]   step;
    logic                halted;
    logic                instr_done;
    logic                illegal_op;
    logic                seq_error;

    modport master (
        output opcode, mem_stall, resume,
        input  state, step, halted, instr_done, illegal_op, seq_error
    );

    modport slave (
        input  opcode, mem_stall, resume,
        output state, step, halted, instr_done, illegal_op, seq_error
    );
endinterface

// File: rtl/cpu_microcode_rom.sv
// Combinational decode table: (opcode, step) -> control state, illegal flag.
module cpu_microcode_rom
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned STEP_W   = 3
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [STEP_W-1:0]   i_step,
    output state_e              o_state,
    output logic                o_illegal
);

    // Steps 0/1 are the shared fetch; anything not in the table decodes to NEXT.
    always_comb begin
        o_state   = STATE_NEXT;
        o_illegal = 1'b0;
        if (i_step == STEP_W'(0)) begin
            o_state = STATE_FETCH_PC;
        end else if (i_step == STEP_W'(1)) begin
            o_state = STATE_FETCH_INST;
        end else begin
            case (i_opcode)
                OPCODE_W'(OP_NOP): o_state = STATE_NEXT;
                OPCODE_W'(OP_HLT): if (i_step == STEP_W'(2)) o_state = STATE_HALT;
                OPCODE_W'(OP_OUT): if (i_step == STEP_W'(2)) o_state = STATE_OUT_A;
                OPCODE_W'(OP_JMP), OPCODE_W'(OP_JEZ), OPCODE_W'(OP_JNZ): begin
                    case (i_step)
                        STEP_W'(2): o_state = STATE_FETCH_PC;
                        STEP_W'(3): o_state = STATE_JUMP;
                        default:    o_state = STATE_NEXT;
                    endcase
                end
                OPCODE_W'(OP_LDA): begin
                    case (i_step)
                        STEP_W'(2): o_state = STATE_FETCH_PC;
                        STEP_W'(3): o_state = STATE_LOAD_ADDR;
                        STEP_W'(4): o_state = STATE_RAM_A;
                        default:    o_state = STATE_NEXT;
                    endcase
                end
                OPCODE_W'(OP_STA): begin
                    case (i_step)
                        STEP_W'(2): o_state = STATE_FETCH_PC;
                        STEP_W'(3): o_state = STATE_LOAD_ADDR;
                        STEP_W'(4): o_state = STATE_STORE_A;
                        default:    o_state = STATE_NEXT;
                    endcase
                end
                OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                    case (i_step)
                        STEP_W'(2): o_state = STATE_FETCH_PC;
                        STEP_W'(3): o_state = STATE_LOAD_ADDR;
                        STEP_W'(4): o_state = STATE_RAM_B;
                        STEP_W'(5): o_state = STATE_ALU_OP;
                        default:    o_state = STATE_NEXT;
                    endcase
                end
                default: o_illegal = (i_step == STEP_W'(2));
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Microcode sequencer: step counter, stall/halt/resume priority, overrun guard.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 8,
    parameter int unsigned STATE_W   = 4,
    parameter int unsigned MAX_STEPS = 8,
    parameter int unsigned STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic           clk,
    input  logic           reset,
    cpu_sequencer_if.slave bus
);

    state_e            r_state;
    logic [STEP_W-1:0] r_step;
    logic              r_illegal;
    logic              r_seq_error;

    logic [STEP_W-1:0] w_nstep;
    state_e            w_rom_state;
    logic              w_rom_illegal;
    logic              w_stall;
    logic              w_guard;

    assign w_nstep = r_step + STEP_W'(1);
    assign w_stall = bus.mem_stall && is_mem_state(r_state);
    assign w_guard = (w_nstep == STEP_W'(MAX_STEPS - 1)) && (w_rom_state != STATE_NEXT);

    cpu_microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom (
        .i_opcode  (bus.opcode),
        .i_step    (w_nstep),
        .o_state   (w_rom_state),
        .o_illegal (w_rom_illegal)
    );

    // Advance one step per clock; stall holds, HALT waits for resume, NEXT restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= STATE_FETCH_PC;
            r_step      <= '0;
            r_illegal   <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_illegal   <= 1'b0;
            r_seq_error <= 1'b0;
            if (!w_stall) begin
                if (r_state == STATE_HALT) begin
                    if (bus.resume) begin
                        r_state <= STATE_NEXT;
                        r_step  <= w_nstep;
                    end
                end else if (r_state == STATE_NEXT) begin
                    r_state <= STATE_FETCH_PC;
                    r_step  <= '0;
                end else begin
                    r_step    <= w_nstep;
                    r_illegal <= w_rom_illegal;
                    if (w_guard) begin
                        r_state     <= STATE_NEXT;
                        r_seq_error <= 1'b1;
                    end else begin
                        r_state <= w_rom_state;
                    end
                end
            end
        end
    end

    assign bus.state      = STATE_W'(r_state);
    assign bus.step       = r_step;
    assign bus.halted     = (r_state == STATE_HALT);
    assign bus.instr_done = (r_state == STATE_NEXT);
    assign bus.illegal_op = r_illegal;
    assign bus.seq_error  = r_seq_error;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: two sequencers (MAX_STEPS 8 and 6) against a table-driven model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [3:0] NO_ST = 4'hF;

    typedef struct {
        logic [3:0] st;
        int         step;
        logic       ill;
        logic       serr;
    } mdl_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    mdl_t m8, m6;
    mdl_t q8[$];
    mdl_t q6[$];

    always #5 clk = ~clk;

    cpu_sequencer_if #(.OPCODE_W(8), .STATE_W(4), .STEP_W(3)) ifc8 ();
    cpu_sequencer_if #(.OPCODE_W(8), .STATE_W(4), .STEP_W(3)) ifc6 ();

    cpu_sequencer #(.OPCODE_W(8), .STATE_W(4), .MAX_STEPS(8)) u_dut8 (
        .clk (clk), .reset (reset), .bus (ifc8)
    );
    cpu_sequencer #(.OPCODE_W(8), .STATE_W(4), .MAX_STEPS(6)) u_dut6 (
        .clk (clk), .reset (reset), .bus (ifc6)
    );

    // Instruction programs as listed in the ISA table; returns {illegal, state}.
    function automatic logic [4:0] prog_at(input logic [7:0] op, input int idx);
        logic [3:0] p[$];
        logic       unk;
        unk = 1'b0;
        p.push_back(STATE_FETCH_PC);
        p.push_back(STATE_FETCH_INST);
        case (op)
            OP_NOP: p.push_back(STATE_NEXT);
            OP_HLT: p.push_back(STATE_HALT);
            OP_OUT: begin p.push_back(STATE_OUT_A); p.push_back(STATE_NEXT); end
            OP_JMP, OP_JEZ, OP_JNZ: begin
                p.push_back(STATE_FETCH_PC); p.push_back(STATE_JUMP); p.push_back(STATE_NEXT);
            end
            OP_LDA: begin
                p.push_back(STATE_FETCH_PC); p.push_back(STATE_LOAD_ADDR);
                p.push_back(STATE_RAM_A); p.push_back(STATE_NEXT);
            end
            OP_STA: begin
                p.push_back(STATE_FETCH_PC); p.push_back(STATE_LOAD_ADDR);
                p.push_back(STATE_STORE_A); p.push_back(STATE_NEXT);
            end
            OP_ADD, OP_SUB: begin
                p.push_back(STATE_FETCH_PC); p.push_back(STATE_LOAD_ADDR);
                p.push_back(STATE_RAM_B); p.push_back(STATE_ALU_OP); p.push_back(STATE_NEXT);
            end
            default: begin unk = 1'b1; p.push_back(STATE_NEXT); end
        endcase
        if (idx < p.size()) return {unk && (idx == 2), p[idx]};
        return {1'b0, 4'(STATE_NEXT)};
    endfunction

    // One clock of the reference model under the sequencing rules.
    function automatic mdl_t mstep(input int mx, input mdl_t m, input logic rst,
                                   input logic stall, input logic res, input logic [7:0] op);
        mdl_t       r;
        logic [4:0] t;
        int         n;
        r      = m;
        r.ill  = 1'b0;
        r.serr = 1'b0;
        if (rst) begin
            r.st = STATE_FETCH_PC; r.step = 0;
        end else if (stall && (m.st inside {STATE_FETCH_INST, STATE_RAM_A, STATE_RAM_B, STATE_STORE_A})) begin
            r.st = m.st;
        end else if (m.st == STATE_HALT) begin
            if (res) begin r.st = STATE_NEXT; r.step = m.step + 1; end
        end else if (m.st == STATE_NEXT) begin
            r.st = STATE_FETCH_PC; r.step = 0;
        end else begin
            n = m.step + 1;
            t = prog_at(op, n);
            r.st  = t[3:0];
            r.ill = t[4];
            if (n == mx - 1 && t[3:0] != STATE_NEXT) begin
                r.st = STATE_NEXT; r.serr = 1'b1;
            end
            r.step = n;
        end
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the expected outcome.
    task automatic cyc(input logic rst, input logic st, input logic rs, input logic [7:0] op);
        @(negedge clk);
        reset          = rst;
        ifc8.mem_stall = st;  ifc6.mem_stall = st;
        ifc8.resume    = rs;  ifc6.resume    = rs;
        ifc8.opcode    = op;  ifc6.opcode    = op;
        m8 = mstep(8, m8, rst, st, rs, op);
        m6 = mstep(6, m6, rst, st, rs, op);
        q8.push_back(m8);
        q6.push_back(m6);
    endtask

    // Run one instruction until it reaches NEXT, then one more cycle back to fetch.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] stall_st, input int stall_n,
                             input int halt_hold, input logic [3:0] res_st);
        int stalls = 0;
        int halts  = 0;
        for (int i = 0; i < 80; i++) begin
            logic st, rs;
            st = (m8.st == stall_st) && (stalls < stall_n);
            if (st) stalls++;
            rs = 1'b0;
            if (m8.st == STATE_HALT) begin
                rs = (halts >= halt_hold);
                st = rs;
                halts++;
            end else if (m8.st == res_st) begin
                rs = 1'b1;
            end
            cyc(1'b0, st, rs, op);
            if (m8.st == STATE_NEXT) break;
        end
        cyc(1'b0, 1'b0, 1'b0, op);
    endtask

    task automatic chk(input string name, input mdl_t e, input logic [3:0] s, input logic [2:0] stp,
                       input logic h, input logic d, input logic il, input logic se);
        logic [10:0] act, req;
        act = {s, stp, h, d, il, se};
        req = {e.st, 3'(e.step), e.st == STATE_HALT, e.st == STATE_NEXT, e.ill, e.serr};
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t got state=%0d step=%0d h/d/il/se=%b, need state=%0d step=%0d h/d/il/se=%b",
                     name, $time, act[10:7], act[6:4], act[3:0], req[10:7], req[6:4], req[3:0]);
        end
    endtask

    // Monitor: after every active edge compare each DUT with its oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0)
                chk("dut8", q8.pop_front(), ifc8.state, ifc8.step, ifc8.halted,
                    ifc8.instr_done, ifc8.illegal_op, ifc8.seq_error);
            if (q6.size() > 0)
                chk("dut6", q6.pop_front(), ifc6.state, ifc6.step, ifc6.halted,
                    ifc6.instr_done, ifc6.illegal_op, ifc6.seq_error);
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [7:0] ops[10];
        logic [7:0] cur_op;
        ops = '{OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT, OP_JMP, OP_JEZ, OP_JNZ, OP_HLT};
        reset = 1'b1;
        ifc8.mem_stall = 1'b0; ifc6.mem_stall = 1'b0;
        ifc8.resume    = 1'b0; ifc6.resume    = 1'b0;
        ifc8.opcode    = OP_NOP; ifc6.opcode  = OP_NOP;
        m8 = '{st: STATE_FETCH_PC, step: 0, ill: 1'b0, serr: 1'b0};
        m6 = m8;

        cyc(1'b1, 1'b0, 1'b0, OP_NOP);
        cyc(1'b1, 1'b1, 1'b1, OP_NOP);
        run_instr(OP_LDA, NO_ST, 0, 0, NO_ST);
        run_instr(OP_ADD, STATE_RAM_B, 3, 0, NO_ST);
        run_instr(OP_ADD, STATE_LOAD_ADDR, 1, 0, NO_ST);
        run_instr(OP_STA, STATE_STORE_A, 2, 0, NO_ST);
        run_instr(OP_HLT, NO_ST, 0, 20, NO_ST);
        run_instr(OP_OUT, NO_ST, 0, 0, STATE_OUT_A);
        run_instr(8'hFF, NO_ST, 0, 0, NO_ST);
        run_instr(OP_NOP, STATE_FETCH_INST, 2, 0, NO_ST);
        run_instr(OP_JNZ, NO_ST, 0, 0, NO_ST);

        // Reset while stalled in RAM_A.
        for (int i = 0; i < 20 && m8.st != STATE_RAM_A; i++) cyc(1'b0, 1'b0, 1'b0, OP_LDA);
        cyc(1'b0, 1'b1, 1'b0, OP_LDA);
        cyc(1'b0, 1'b1, 1'b0, OP_LDA);
        cyc(1'b1, 1'b1, 1'b0, OP_LDA);
        cyc(1'b0, 1'b0, 1'b0, OP_NOP);
        // Reset while halted.
        for (int i = 0; i < 20 && m8.st != STATE_HALT; i++) cyc(1'b0, 1'b0, 1'b0, OP_HLT);
        cyc(1'b0, 1'b1, 1'b0, OP_HLT);
        cyc(1'b1, 1'b0, 1'b0, OP_HLT);
        cyc(1'b0, 1'b0, 1'b0, OP_NOP);

        cur_op = OP_NOP;
        for (int i = 0; i < 3000; i++) begin
            logic st, rs, rst;
            if ((m8.st == STATE_NEXT) || ($urandom_range(0, 99) == 0)) begin
                if ($urandom_range(0, 9) == 0) cur_op = 8'($urandom);
                else cur_op = ops[$urandom_range(0, 9)];
            end
            st  = ($urandom_range(0, 9) < 3);
            rs  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc(rst, st, rs, cur_op);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q8.size() != 0 || q6.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, need 0/0", q8.size(), q6.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
